// File: rtl/loadrc.sv
// Toeplitz seed loader: assembles row0 (N bits) and col0 (L bits) from a BS-bit
// word stream. Optional top-left corner consistency check under LOADRC_CORNER_CHECK_EN.
module loadrc #(
   parameter int BS = 64,
   parameter int N  = 256,
   parameter int L  = 128
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          start,
   input  logic          abort,
   input  logic [BS-1:0] in_data,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [N-1:0]  row0,
   output logic [N-1:0]  rrow0,
   output logic [L-1:0]  col0,
   output logic          seed_valid,
   output logic          busy,
   output logic          err
);
   localparam int ROW_WORDS = N / BS;
   localparam int COL_WORDS = L / BS;
   localparam int MAX_WORDS = ((N > L) ? N : L) / BS;
   localparam int CW        = $clog2(MAX_WORDS) + 1;
   localparam logic [CW-1:0] ROW_LAST = CW'(ROW_WORDS - 1);
   localparam logic [CW-1:0] COL_LAST = CW'(COL_WORDS - 1);

   if ((N % BS) != 0 || (L % BS) != 0) begin : g_bad_param
      $error("loadrc: N and L must be integer multiples of BS");
   end

   typedef enum logic [1:0] {IDLE, LOAD_ROW, LOAD_COL, DONE} state_t;

   state_t         r_state, w_nxt;
   logic [CW-1:0]  r_cnt;
   logic [N-1:0]   r_row0;
   logic [L-1:0]   r_col0;
   logic           w_loading, w_ld, w_wr;

   assign w_loading = (r_state == LOAD_ROW) || (r_state == LOAD_COL);
   assign w_ld      = start && ((r_state == IDLE) || (r_state == DONE));
   // A word arriving alongside abort is accepted by the handshake but dropped.
   assign w_wr      = w_loading && in_valid && !abort;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_nxt;
   end

   always_comb begin
      w_nxt = r_state;
      case (r_state)
         IDLE:     if (start) w_nxt = LOAD_ROW;
         LOAD_ROW: if (abort) w_nxt = IDLE;
                   else if (w_wr && r_cnt == ROW_LAST) w_nxt = LOAD_COL;
         LOAD_COL: if (abort) w_nxt = IDLE;
                   else if (w_wr && r_cnt == COL_LAST) w_nxt = DONE;
         DONE:     if (start) w_nxt = LOAD_ROW;
         default:  w_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt  <= '0;
         r_row0 <= '0;
         r_col0 <= '0;
      end else if (w_ld) begin
         r_cnt  <= '0;
         r_row0 <= '0;
         r_col0 <= '0;
      end else if (w_loading && abort) begin
         r_cnt <= '0;
      end else if (w_wr) begin
         if (r_state == LOAD_ROW) begin
            for (int k = 0; k < ROW_WORDS; k++)
               if (r_cnt == CW'(k)) r_row0[k*BS +: BS] <= in_data;
            r_cnt <= (r_cnt == ROW_LAST) ? '0 : r_cnt + 1'b1;
         end else begin
            for (int k = 0; k < COL_WORDS; k++)
               if (r_cnt == CW'(k)) r_col0[k*BS +: BS] <= in_data;
            r_cnt <= (r_cnt == COL_LAST) ? '0 : r_cnt + 1'b1;
         end
      end
   end

`ifdef LOADRC_CORNER_CHECK_EN
   logic r_err;
   // row0[0] and col0[0] name the same matrix element; they must agree.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)  r_err <= 1'b0;
      else if (w_ld) r_err <= 1'b0;
      else if (w_wr && r_state == LOAD_COL && r_cnt == '0 && in_data[0] != r_row0[0])
         r_err <= 1'b1;
   end
   assign err = r_err;
`else
   assign err = 1'b0;
`endif

   always_comb begin
      for (int i = 0; i < N; i++) rrow0[i] = r_row0[N-1-i];
   end

   assign row0       = r_row0;
   assign col0       = r_col0;
   assign in_ready   = w_loading;
   assign busy       = w_loading;
   assign seed_valid = (r_state == DONE);
endmodule

// File: tb/tb_loadrc.sv
// Randomized bench for loadrc against a word-count reference model.
module tb_loadrc;
   localparam int BS = 64, N = 256, L = 128;
   localparam int NR = N / BS, NC = L / BS;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0, abort = 1'b0, in_valid = 1'b0;
   logic [BS-1:0] in_data = '0;
   logic          in_ready, seed_valid, busy, err;
   logic [N-1:0]  row0, rrow0;
   logic [L-1:0]  col0;

   int n_chk = 0, n_pass = 0;

   // reference model: a load is just "count accepted words, fill row then col"
   bit           m_busy = 0, m_done = 0, m_err = 0;
   int           m_n = 0;
   logic [N-1:0] m_row = '0;
   logic [L-1:0] m_col = '0;

   loadrc #(.BS(BS), .N(N), .L(L)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .row0(row0), .rrow0(rrow0), .col0(col0),
      .seed_valid(seed_valid), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [N-1:0] rev(input logic [N-1:0] v);
      logic [N-1:0] r;
      for (int i = 0; i < N; i++) r[i] = v[N-1-i];
      return r;
   endfunction

   task automatic model_edge(input bit st, input bit ab, input bit v, input logic [BS-1:0] d);
      if (m_busy) begin
         if (ab) m_busy = 0;
         else if (v) begin
            if (m_n < NR) m_row[m_n*BS +: BS] = d;
            else begin
`ifdef LOADRC_CORNER_CHECK_EN
               if (m_n == NR && d[0] != m_row[0]) m_err = 1;
`endif
               m_col[(m_n-NR)*BS +: BS] = d;
            end
            m_n++;
            if (m_n == NR + NC) begin m_busy = 0; m_done = 1; end
         end
      end else if (st) begin
         m_busy = 1; m_done = 0; m_n = 0; m_row = '0; m_col = '0; m_err = 0;
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".flags"}, N'({seed_valid, busy, in_ready, err}),
          N'({m_done, m_busy, m_busy, m_err}));
      chk({tag, ".row0"}, row0, m_row);
      chk({tag, ".rrow0"}, rrow0, rev(m_row));
      chk({tag, ".col0"}, N'(col0), N'(m_col));
   endtask

   task automatic cyc(input string tag, input bit st, input bit ab, input bit v,
                      input logic [BS-1:0] d);
      start = st; abort = ab; in_valid = v; in_data = d;
      @(posedge clk);
      model_edge(st, ab, v, d);
      #1;
      start = 0; abort = 0; in_valid = 0;
      check_all(tag);
   endtask

   task automatic load(input string tag, input logic [BS-1:0] w [NR+NC], input int bubble_pct);
      int k = 0;
      int guard = 0;
      cyc(tag, 1, 0, 0, '0);
      while (k < NR + NC && guard < 200) begin
         if ($urandom_range(99) < bubble_pct) cyc(tag, 0, 0, 0, {$urandom, $urandom});
         else begin cyc(tag, 0, 0, 1, w[k]); k++; end
         guard++;
      end
      if (guard >= 200) chk({tag, ".timeout"}, N'(guard), N'(0));
   endtask

   logic [BS-1:0] wv [NR+NC];

   initial begin
      #12;
      check_all("reset");
      reset_n = 1;
      @(posedge clk); #1;
      check_all("idle");

      // directed load, in_valid held high
      wv = '{64'h0123456789ABCDEF, 64'h1, 64'h0, 64'hFFFFFFFFFFFFFFFF, 64'h5, 64'hA0};
      load("full", wv, 0);
      chk("full.row0_const", row0, {64'hFFFFFFFFFFFFFFFF, 64'h0, 64'h1, 64'h0123456789ABCDEF});
      chk("full.col0_const", N'(col0), N'({64'hA0, 64'h5}));
      chk("full.rrow_ends", N'({rrow0[255], rrow0[0], seed_valid}), N'(3'b111));
      cyc("done_hold", 0, 0, 1, 64'hDEAD);
      cyc("done_abort", 0, 1, 0, '0);

      // bubbles: same seed, random gaps
      load("bubble", wv, 60);
      cyc("bubble_tail", 0, 0, 0, '0);

      // abort after two row words, then a fresh full load
      cyc("ab.start", 1, 0, 0, '0);
      cyc("ab.w0", 0, 0, 1, 64'hFFFF_0000_FFFF_0000);
      cyc("ab.w1", 0, 0, 1, 64'h1234_5678_9ABC_DEF0);
      cyc("ab.abort", 0, 1, 1, 64'h5555);
      cyc("ab.idle", 0, 0, 1, 64'h7777);
      for (int i = 0; i < NR + NC; i++) wv[i] = {$urandom, $urandom};
      wv[1] = '0;
      load("ab.reload", wv, 20);

      // start during LOAD_COL is ignored
      cyc("sb.start", 1, 0, 0, '0);
      for (int i = 0; i < NR + 1; i++) cyc("sb.w", 0, 0, 1, {$urandom, $urandom});
      cyc("sb.start_busy", 1, 0, 0, '0);
      cyc("sb.last", 0, 0, 1, {$urandom, $urandom});
      // start in DONE restarts and drops seed_valid
      cyc("sb.restart", 1, 0, 0, '0);
      for (int i = 0; i < NR + NC; i++) cyc("sb.new", 0, 0, 1, {$urandom, $urandom});

      // corner mismatch then match
      wv = '{64'h1, 64'h2, 64'h3, 64'h4, 64'h0, 64'h6};
      load("corner_bad", wv, 0);
      wv[4] = 64'h1;
      load("corner_ok", wv, 10);

      // async reset mid LOAD_ROW, between edges
      cyc("ar.start", 1, 0, 0, '0);
      cyc("ar.w0", 0, 0, 1, 64'hCAFE);
      #3 reset_n = 0;
      #1;
      m_busy = 0; m_done = 0; m_err = 0; m_n = 0; m_row = '0; m_col = '0;
      check_all("async_rst");
      #2 reset_n = 1;
      @(posedge clk); #1;
      check_all("post_rst");

      // random mix of start/abort/valid
      for (int i = 0; i < 400; i++)
         cyc("rand", ($urandom_range(7) == 0), ($urandom_range(15) == 0),
             $urandom_range(1) == 1, {$urandom, $urandom});

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/loadrc.md
Name: loadrc

Overview:
- Writer-side counterpart to the Toeplitz row/column reader.
- Accepts the Toeplitz seed as a stream of BS-bit words over a valid/ready handshake and assembles row0 (N bits) and col0 (L bits).
- Presents row0, the bit-reversed rrow0 and col0, plus a valid flag, to the downstream Toeplitz hashing datapath.
- Lets the seed be reloaded at run time instead of being fixed at elaboration.

Parameters:
- BS, 64, word width of the input stream; N and L must be integer multiples of BS (elaboration-time assertion otherwise).
- N, 256, row length in bits.
- L, 128, column length in bits.

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse; begins a new load.
- abort  input  1  single-cycle pulse; cancels a load in progress.
- in_data  input  BS  seed word.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts a word this cycle.
- row0  output  N  first row of the Toeplitz matrix.
- rrow0  output  N  row0 bit-reversed: rrow0[i] = row0[N-1-i].
- col0  output  L  first column of the Toeplitz matrix.
- seed_valid  output  1  row0/rrow0/col0 hold a complete seed.
- busy  output  1  a load is in progress.
- err  output  1  seed consistency error, sticky until the next start.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state = IDLE.
  - row0, col0 and the word counter are all zero.
  - rrow0 is therefore zero.
  - seed_valid, busy, in_ready and err are 0.
- States: IDLE, LOAD_ROW, LOAD_COL, DONE.
- Accept: a word transfers on a rising edge where in_valid && in_ready. in_ready is 1 exactly in LOAD_ROW and LOAD_COL, and is driven from the registered state only (no combinational path from in_valid).
- IDLE:
  - start -> LOAD_ROW, counter = 0, busy = 1, err cleared.
- LOAD_ROW:
  - Word k (k = 0 .. N/BS-1) is written to row0[k*BS +: BS]: LSB word first, bit 0 of the word goes to the lowest index.
  - After word N/BS-1 -> LOAD_COL, counter = 0.
- LOAD_COL:
  - Word k (k = 0 .. L/BS-1) is written to col0[k*BS +: BS].
  - After word L/BS-1 -> DONE. On the next cycle seed_valid = 1 and busy = 0.
  - Latency is 1 cycle from the last accepted word to seed_valid.
- DONE:
  - Outputs hold.
  - start -> LOAD_ROW: seed_valid drops on the next cycle, counter = 0, err cleared.
- Data and validity:
  - row0 and col0 are cleared at start.
  - While busy, row0/col0 show partial contents; consumers must gate on seed_valid.
  - rrow0 is a pure wiring reversal of the row0 register and has the same timing.
- Counter: width $clog2(max(N,L)/BS)+1. It wraps only by state transition, never arithmetically.
- start while busy: ignored.
- abort while busy:
  - -> IDLE on the next edge; busy = 0, seed_valid = 0.
  - Partial row0/col0 contents are retained.
  - Any word offered in the same cycle is still accepted (in_ready was high) but discarded by the transition.
- abort in IDLE or DONE: no effect.
- start and abort in the same cycle: abort wins if busy; start wins otherwise.
- in_valid outside LOAD states: ignored, no state change.
- reset_n asserted mid-load: immediate return to reset values.

Optional Feature:
- Macro: LOADRC_CORNER_CHECK_EN.
- Defined:
  - row0[0] and col0[0] are the same matrix element (top-left corner).
  - When the first col word is accepted, compare its bit 0 with row0[0].
  - On mismatch, err = 1 from the next cycle, sticky until the next start. The load still completes and seed_valid still asserts.
- Not defined: err is tied to 0 and no comparison logic is generated.

Test Plan:
- Full load, defaults: start, then 4 row words 64'h0123456789ABCDEF, 64'h1, 64'h0, 64'hFFFFFFFFFFFFFFFF and 2 col words 64'h5, 64'hA0, in_valid held high.
  - Check row0 = {64'hFFFF...F, 64'h0, 64'h1, 64'h0123456789ABCDEF} and col0 = {64'hA0, 64'h5}.
  - Check rrow0 = bit-reverse of row0 (rrow0[255] = 1, rrow0[0] = 1).
  - Check seed_valid = 1 exactly 1 cycle after the 6th accepted word.
- Backpressure/bubbles: in_valid toggles 1,0,0,1,... -> same final row0/col0 as the full load; counter advances only on accept; in_ready = 0 in IDLE and DONE.
- Abort mid-load: start, accept 2 row words, abort.
  - Next cycle: busy = 0, seed_valid = 0, in_ready = 0.
  - Then start plus a full load -> correct seed; row0 bits from the aborted attempt are cleared.
- Reload and start-while-busy:
  - start during LOAD_COL is ignored and the load completes.
  - start in DONE drops seed_valid the next cycle; a new seed then replaces the old one.
- Async reset: assert reset_n = 0 between clock edges during LOAD_ROW -> all outputs zero immediately, before the next edge; on release the block is in IDLE.
- Corner check (with LOADRC_CORNER_CHECK_EN):
  - Row word 0 = 64'h1, col word 0 = 64'h0 -> err = 1 and seed_valid = 1 at completion.
  - Matching bits -> err = 0.
  - Without the macro, err stays 0 in both cases.
